// File: rtl/icon_pkg.sv
// Shared types and helpers for icon interconnect stages: default widths,
// the request record and the routing-bit extractor used by icon_node users.
package icon_pkg;

  localparam int ICON_ADDR_W     = 9;
  localparam int ICON_DATA_W     = 1;
  localparam int ICON_STAGE      = 8;
  localparam int ICON_ADDR_MAX_W = 32;

  typedef struct packed {
    logic [ICON_ADDR_W-1:0] addr;
    logic [ICON_DATA_W-1:0] data;
  } req_t;

  // Returns the address bit a node at the given stage switches on.
  function automatic logic stage_bit(input logic [ICON_ADDR_MAX_W-1:0] addr,
                                     input int unsigned stage);
    logic r_bit;
    if (stage < 32'(ICON_ADDR_MAX_W)) begin
      r_bit = addr[stage[4:0]];
    end else begin
      r_bit = 1'b0;
    end
    return r_bit;
  endfunction

endpackage

// File: rtl/icon_ingress_if.sv
// Client-request and node-facing lane bundle of icon_ingress.
// slave = ingress side, master = client/node side.
interface icon_ingress_if
  import icon_pkg::*;
#(
  parameter int ADDR_W = ICON_ADDR_W,
  parameter int DATA_W = ICON_DATA_W
);

  logic              i_req_valid_0;
  logic              i_req_valid_1;
  logic              o_req_ready_0;
  logic              o_req_ready_1;
  logic [ADDR_W-1:0] i_req_addr_0;
  logic [ADDR_W-1:0] i_req_addr_1;
  logic [DATA_W-1:0] i_req_data_0;
  logic [DATA_W-1:0] i_req_data_1;
  logic              o_valid_0;
  logic              o_valid_1;
  logic [ADDR_W-1:0] o_addr_0;
  logic [ADDR_W-1:0] o_addr_1;
  logic [DATA_W-1:0] o_data_0;
  logic [DATA_W-1:0] o_data_1;

  modport slave (
    input  i_req_valid_0, i_req_valid_1,
    input  i_req_addr_0, i_req_addr_1,
    input  i_req_data_0, i_req_data_1,
    output o_req_ready_0, o_req_ready_1,
    output o_valid_0, o_valid_1,
    output o_addr_0, o_addr_1,
    output o_data_0, o_data_1
  );

  modport master (
    output i_req_valid_0, i_req_valid_1,
    output i_req_addr_0, i_req_addr_1,
    output i_req_data_0, i_req_data_1,
    input  o_req_ready_0, o_req_ready_1,
    input  o_valid_0, o_valid_1,
    input  o_addr_0, o_addr_1,
    input  o_data_0, o_data_1
  );

endinterface

// File: rtl/icon_fifo.sv
// Per-lane request FIFO. A written entry becomes poppable one cycle after it
// is accepted (o_head_valid), giving the ingress its two-edge issue latency.
module icon_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_ready,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_count;
  logic [OCC_W-1:0] r_avail;
  logic             r_push_d;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_count_next;
  logic [OCC_W-1:0] w_avail_next;

  assign w_push = i_push && r_ready && (r_count != OCC_FULL);
  assign w_pop  = i_pop && (r_avail != OCC_ZERO);

  // Occupancy and visible-entry count; entries accepted last edge become visible now.
  always_comb begin
    w_count_next = r_count;
    w_avail_next = r_avail;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + OCC_ONE;
      2'b01:   w_count_next = r_count - OCC_ONE;
      default: w_count_next = r_count;
    endcase
    case ({r_push_d, w_pop})
      2'b10:   w_avail_next = r_avail + OCC_ONE;
      2'b01:   w_avail_next = r_avail - OCC_ONE;
      default: w_avail_next = r_avail;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr   <= PTR_ZERO;
      r_rptr   <= PTR_ZERO;
      r_count  <= OCC_ZERO;
      r_avail  <= OCC_ZERO;
      r_push_d <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_wptr   <= w_push ? (r_wptr + PTR_ONE) : r_wptr;
      r_rptr   <= w_pop  ? (r_rptr + PTR_ONE) : r_rptr;
      r_count  <= w_count_next;
      r_avail  <= w_avail_next;
      r_push_d <= w_push;
      // Ready follows occupancy only, so a pop never frees space in the same cycle.
      r_ready  <= (w_count_next != OCC_FULL);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_ready      = r_ready;
  assign o_full       = (r_count == OCC_FULL);
  assign o_empty      = (r_count == OCC_ZERO);
  assign o_head_valid = (r_avail != OCC_ZERO);
  assign o_head       = r_mem[r_rptr];

endmodule

// File: rtl/icon_ingress.sv
// Two-lane injection stage for a first-stage icon node: buffers client requests and
// never presents two valid lanes needing the same output half. Optional conflict
// counter enabled by ICON_INGRESS_STATS_EN.
module icon_ingress
  import icon_pkg::*;
#(
  parameter int DATA_W = ICON_DATA_W,
  parameter int ADDR_W = ICON_ADDR_W,
  parameter int STAGE  = ICON_STAGE,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  icon_ingress_if.slave  bus
`ifdef ICON_INGRESS_STATS_EN
  ,
  output logic [CNT_W-1:0] o_conflict_cnt
`endif
);

  localparam int REQ_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lane_req_t;

  lane_req_t w_wr0, w_wr1, w_head0, w_head1;
  logic w_ready0, w_ready1, w_full0, w_full1, w_empty0, w_empty1;
  logic w_hv0, w_hv1, w_v0, w_v1, w_b0, w_b1;
  logic w_issue0, w_issue1, w_conflict;

  logic              r_rr;
  logic              r_valid0, r_valid1;
  logic [ADDR_W-1:0] r_addr0, r_addr1;
  logic [DATA_W-1:0] r_data0, r_data1;

  assign w_wr0 = '{addr: bus.i_req_addr_0, data: bus.i_req_data_0};
  assign w_wr1 = '{addr: bus.i_req_addr_1, data: bus.i_req_data_1};

  icon_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo0 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (bus.i_req_valid_0),
    .i_wdata      (w_wr0),
    .i_pop        (w_issue0),
    .o_ready      (w_ready0),
    .o_full       (w_full0),
    .o_empty      (w_empty0),
    .o_head_valid (w_hv0),
    .o_head       (w_head0)
  );

  icon_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo1 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (bus.i_req_valid_1),
    .i_wdata      (w_wr1),
    .i_pop        (w_issue1),
    .o_ready      (w_ready1),
    .o_full       (w_full1),
    .o_empty      (w_empty1),
    .o_head_valid (w_hv1),
    .o_head       (w_head1)
  );

  assign bus.o_req_ready_0 = w_ready0 & ~w_full0;
  assign bus.o_req_ready_1 = w_ready1 & ~w_full1;

  assign w_v0 = w_hv0 & ~w_empty0;
  assign w_v1 = w_hv1 & ~w_empty1;
  assign w_b0 = stage_bit(ICON_ADDR_MAX_W'(w_head0.addr), unsigned'(STAGE));
  assign w_b1 = stage_bit(ICON_ADDR_MAX_W'(w_head1.addr), unsigned'(STAGE));

  // Arbiter: on a routing-bit conflict only lane rr goes; the loser wins next time.
  always_comb begin
    w_issue0   = 1'b0;
    w_issue1   = 1'b0;
    w_conflict = 1'b0;
    case ({w_v0, w_v1})
      2'b10: w_issue0 = 1'b1;
      2'b01: w_issue1 = 1'b1;
      2'b11: begin
        if (w_b0 != w_b1) begin
          w_issue0 = 1'b1;
          w_issue1 = 1'b1;
        end else begin
          w_conflict = 1'b1;
          w_issue0   = ~r_rr;
          w_issue1   = r_rr;
        end
      end
      default: begin
        w_issue0   = 1'b0;
        w_issue1   = 1'b0;
        w_conflict = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rr     <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_addr0  <= {ADDR_W{1'b0}};
      r_addr1  <= {ADDR_W{1'b0}};
      r_data0  <= {DATA_W{1'b0}};
      r_data1  <= {DATA_W{1'b0}};
    end else begin
      r_rr     <= w_conflict ? ~r_rr : r_rr;
      r_valid0 <= w_issue0;
      r_valid1 <= w_issue1;
      r_addr0  <= w_issue0 ? w_head0.addr : r_addr0;
      r_data0  <= w_issue0 ? w_head0.data : r_data0;
      r_addr1  <= w_issue1 ? w_head1.addr : r_addr1;
      r_data1  <= w_issue1 ? w_head1.data : r_data1;
    end
  end

  assign bus.o_valid_0 = r_valid0;
  assign bus.o_valid_1 = r_valid1;
  assign bus.o_addr_0  = r_addr0;
  assign bus.o_addr_1  = r_addr1;
  assign bus.o_data_0  = r_data0;
  assign bus.o_data_1  = r_data1;

`ifdef ICON_INGRESS_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] r_conflict_cnt;

  // Saturating conflict-cycle counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_conflict_cnt <= {CNT_W{1'b0}};
    end else if (w_conflict && (r_conflict_cnt != CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule
